// File: rtl/pipe_hazard_ctrl.sv
// In-order pipeline hazard controller. A scoreboard shift register tracks every
// instruction past decode. From it this block derives the load-use stall, the
// forwarding selects for the decode-stage sources, the IF/ID flush on a taken
// branch, and the halt-drain sequence.
//
// state   | meaning
// --------+----------------------------------------------------------------
// S_RUN   | normal issue; ID instruction accepted unless a load-use stall
// S_DRAIN | HLT accepted; issue blocked, waiting for HLT to reach last entry
// S_HALTED| processor halted (hlt=1); pipe keeps draining bubbles until reset
module pipe_hazard_ctrl #(
   parameter  int NSTG       = 3,
   parameter  int REG_AW     = 4,
   parameter  int LOAD_READY = 1,
   parameter  int RET_W      = 16,
   localparam int FW         = $clog2(NSTG + 1)
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              issue_valid,
   input  logic              issue_wr,
   input  logic              issue_load,
   input  logic              issue_halt,
   input  logic [REG_AW-1:0] issue_dst,
   input  logic [REG_AW-1:0] issue_src_a,
   input  logic [REG_AW-1:0] issue_src_b,
   input  logic              issue_use_a,
   input  logic              issue_use_b,
   input  logic              branch_taken,
   output logic              stall_if,
   output logic              flush_ifid,
   output logic [FW-1:0]     fwd_a,
   output logic [FW-1:0]     fwd_b,
   output logic [NSTG-1:0]   stage_valid,
   output logic              hlt,
   output logic [RET_W-1:0]  retired
);

   typedef enum logic [1:0] {
      S_RUN    = 2'd0,
      S_DRAIN  = 2'd1,
      S_HALTED = 2'd2
   } state_t;

   state_t            r_state;
   logic              r_hlt;
   logic [NSTG-1:0]   r_vld;
   logic [NSTG-1:0]   r_wr;
   logic [NSTG-1:0]   r_ld;
   logic [NSTG-1:0]   r_hl;
   logic [REG_AW-1:0] r_dst [NSTG];
   logic [RET_W-1:0]  r_retired;

   logic [FW:0]       w_match_a;
   logic [FW:0]       w_match_b;
   logic              w_ld_stall;
   logic              w_stall;
   logic              w_accept;

   // Youngest producer of a source; msb flags a load whose result is not yet
   // forwardable. Scanning oldest-to-youngest lets the youngest match win.
   function automatic logic [FW:0] f_match(input logic [REG_AW-1:0] i_src,
                                          input logic              i_use);
      logic [FW:0] v_res;
      v_res = '0;
      for (int k = NSTG - 1; k >= 0; k--) begin
         if (i_use && (i_src != '0) && r_vld[k] && r_wr[k] && (r_dst[k] == i_src))
            v_res = {(r_ld[k] && (k < LOAD_READY)), FW'(k + 1)};
      end
      return v_res;
   endfunction

   // Hazard detection, forwarding selects, stall, issue and flush decisions.
   always_comb begin
      w_match_a  = f_match(issue_src_a, issue_use_a);
      w_match_b  = f_match(issue_src_b, issue_use_b);
      w_ld_stall = issue_valid & (w_match_a[FW] | w_match_b[FW]);
      w_stall    = w_ld_stall | (r_state != S_RUN);
      w_accept   = issue_valid & ~w_stall;
   end

   assign fwd_a       = w_match_a[FW-1:0];
   assign fwd_b       = w_match_b[FW-1:0];
   assign stall_if    = w_stall;
   // Accept already implies RUN and no stall, so a stalled branch is ignored.
   assign flush_ifid  = branch_taken & w_accept;
   assign stage_valid = r_vld;
   assign hlt         = r_hlt;
   assign retired     = r_retired;

   // Scoreboard shift: entry 0 takes the accepted ID instruction or a bubble.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_vld <= '0;
         r_wr  <= '0;
         r_ld  <= '0;
         r_hl  <= '0;
         for (int k = 0; k < NSTG; k++) r_dst[k] <= '0;
      end else begin
         r_vld    <= {r_vld[NSTG-2:0], w_accept};
         r_wr     <= {r_wr[NSTG-2:0], w_accept & issue_wr};
         r_ld     <= {r_ld[NSTG-2:0], w_accept & issue_load};
         r_hl     <= {r_hl[NSTG-2:0], w_accept & issue_halt};
         r_dst[0] <= w_accept ? issue_dst : '0;
         for (int k = 1; k < NSTG; k++) r_dst[k] <= r_dst[k-1];
      end
   end

   // Halt sequencing: RUN -> DRAIN on accepted HLT -> HALTED when HLT retires.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= S_RUN;
         r_hlt   <= 1'b0;
      end else begin
         case (r_state)
            S_RUN: begin
               if (w_accept && issue_halt) r_state <= S_DRAIN;
            end
            S_DRAIN: begin
               if (r_vld[NSTG-1] && r_hl[NSTG-1]) begin
                  r_state <= S_HALTED;
                  r_hlt   <= 1'b1;
               end
            end
            S_HALTED: begin
               r_hlt <= 1'b1;
            end
            default: begin
               r_state <= S_RUN;
               r_hlt   <= 1'b0;
            end
         endcase
      end
   end

   // Saturating count of real instructions leaving the last entry.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         r_retired <= '0;
      else if (r_vld[NSTG-1] && (r_retired != '1))
         r_retired <= r_retired + RET_W'(1);
   end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Bench for pipe_hazard_ctrl. Two instances share one stimulus stream:
// dut0 (NSTG=3, LOAD_READY=1, RET_W=16) and dut1 (NSTG=5, LOAD_READY=2, RET_W=4).
// The reference model keeps a history of which instruction was accepted in
// each cycle; pipe contents, hazards, halt timing and retire counts are
// derived from instruction ages.
module tb_pipe_hazard_ctrl;

   localparam int NCYC = 4096;
   localparam int N_OF  [2] = '{3, 5};
   localparam int LR_OF [2] = '{1, 2};
   localparam int RMAX  [2] = '{65535, 15};

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   logic       iv, wr, ld, hl, ua, ub, br;
   logic [3:0] dst, sa, sb;

   logic       st0, fl0, h0;
   logic [1:0] fa0, fb0;
   logic [2:0] sv0;
   logic [15:0] rt0;
   logic       st1, fl1, h1;
   logic [2:0] fa1, fb1;
   logic [4:0] sv1;
   logic [3:0] rt1;

   pipe_hazard_ctrl #(.NSTG(3), .REG_AW(4), .LOAD_READY(1), .RET_W(16)) dut0 (
      .clk(clk), .rst_n(rst_n), .issue_valid(iv), .issue_wr(wr), .issue_load(ld),
      .issue_halt(hl), .issue_dst(dst), .issue_src_a(sa), .issue_src_b(sb),
      .issue_use_a(ua), .issue_use_b(ub), .branch_taken(br),
      .stall_if(st0), .flush_ifid(fl0), .fwd_a(fa0), .fwd_b(fb0),
      .stage_valid(sv0), .hlt(h0), .retired(rt0));

   pipe_hazard_ctrl #(.NSTG(5), .REG_AW(4), .LOAD_READY(2), .RET_W(4)) dut1 (
      .clk(clk), .rst_n(rst_n), .issue_valid(iv), .issue_wr(wr), .issue_load(ld),
      .issue_halt(hl), .issue_dst(dst), .issue_src_a(sa), .issue_src_b(sb),
      .issue_use_a(ua), .issue_use_b(ub), .branch_taken(br),
      .stall_if(st1), .flush_ifid(fl1), .fwd_a(fa1), .fwd_b(fb1),
      .stage_valid(sv1), .hlt(h1), .retired(rt1));

   // Reference history: what each configuration accepted in each cycle.
   bit         av  [2][NCYC];
   bit         awr [2][NCYC];
   bit         ald [2][NCYC];
   logic [3:0] adst[2][NCYC];
   int         hcyc[2];
   int         cnt [2];
   int         base;
   int         cyc;
   int         n_chk;
   int         n_pass;

   task automatic chk(input string tag, input int act, input int exp);
      n_chk++;
      if (act == exp) n_pass++;
      else $display("FAIL %s cyc=%0d got=%0d want=%0d", tag, cyc, act, exp);
   endtask

   // Youngest in-flight writer of register s (age k = accepted k+1 cycles ago).
   task automatic model_src(input int i, input logic [3:0] s, input logic u,
                            output int fwd, output bit haz);
      fwd = 0;
      haz = 1'b0;
      if (u && s != 4'd0) begin
         for (int k = 0; k < N_OF[i]; k++) begin
            int a;
            a = cyc - k - 1;
            if (a >= base && av[i][a] && awr[i][a] && adst[i][a] == s) begin
               fwd = k + 1;
               haz = ald[i][a] && (k < LR_OF[i]);
               break;
            end
         end
      end
   endtask

   task automatic check_cfg(input int i);
      int n, fa, fb, sv, er, a;
      bit hza, hzb, run, halted, est, acc, efl;
      n = N_OF[i];
      model_src(i, sa, ua, fa, hza);
      model_src(i, sb, ub, fb, hzb);
      sv = 0;
      for (int k = 0; k < n; k++) begin
         a = cyc - k - 1;
         if (a >= base && av[i][a]) sv = sv | (1 << k);
      end
      a = cyc - n - 1;
      if (a >= base && av[i][a]) cnt[i]++;
      er = (cnt[i] > RMAX[i]) ? RMAX[i] : cnt[i];
      run    = (hcyc[i] < 0);
      halted = (hcyc[i] >= 0) && (cyc >= hcyc[i] + n + 1);
      est = (iv && (hza || hzb)) || !run;
      acc = iv && !est;
      efl = br && acc;
      if (i == 0) begin
         chk("stall0", int'(st0), int'(est));
         chk("flush0", int'(fl0), int'(efl));
         chk("fwda0",  int'(fa0), fa);
         chk("fwdb0",  int'(fb0), fb);
         chk("svld0",  int'(sv0), sv);
         chk("hlt0",   int'(h0),  int'(halted));
         chk("ret0",   int'(rt0), er);
      end else begin
         chk("stall1", int'(st1), int'(est));
         chk("flush1", int'(fl1), int'(efl));
         chk("fwda1",  int'(fa1), fa);
         chk("fwdb1",  int'(fb1), fb);
         chk("svld1",  int'(sv1), sv);
         chk("hlt1",   int'(h1),  int'(halted));
         chk("ret1",   int'(rt1), er);
      end
      av[i][cyc]   = acc;
      awr[i][cyc]  = wr;
      ald[i][cyc]  = ld;
      adst[i][cyc] = dst;
      if (acc && hl && hcyc[i] < 0) hcyc[i] = cyc;
   endtask

   task automatic do_cycle(input bit iv_, input bit wr_, input bit ld_, input bit hl_,
                           input logic [3:0] d_, input logic [3:0] a_, input logic [3:0] b_,
                           input bit ua_, input bit ub_, input bit br_);
      @(posedge clk);
      #1;
      cyc++;
      if (cyc >= NCYC) begin
         $display("FAIL cycle_budget cyc=%0d limit=%0d", cyc, NCYC);
         $fatal(1);
      end
      iv = iv_; wr = wr_; ld = ld_; hl = hl_;
      dst = d_; sa = a_; sb = b_; ua = ua_; ub = ub_; br = br_;
      @(negedge clk);
      check_cfg(0);
      check_cfg(1);
   endtask

   task automatic bubbles(input int n);
      for (int j = 0; j < n; j++) do_cycle(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
   endtask

   // Idle cycle, then a 1 ns reset pulse between edges.
   task automatic pulse_reset();
      do_cycle(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      rst_n = 1'b0;
      #1;
      chk("rst_svld0", int'(sv0), 0);
      chk("rst_hlt0",  int'(h0),  0);
      chk("rst_ret0",  int'(rt0), 0);
      chk("rst_stl0",  int'(st0), 0);
      chk("rst_svld1", int'(sv1), 0);
      chk("rst_hlt1",  int'(h1),  0);
      chk("rst_ret1",  int'(rt1), 0);
      chk("rst_stl1",  int'(st1), 0);
      rst_n = 1'b1;
      base = cyc + 1;
      hcyc = '{-1, -1};
      cnt  = '{0, 0};
   endtask

   initial begin
      n_chk = 0; n_pass = 0; cyc = -1; base = 0;
      hcyc = '{-1, -1};
      cnt  = '{0, 0};
      iv = 0; wr = 0; ld = 0; hl = 0; ua = 0; ub = 0; br = 0;
      dst = 0; sa = 0; sb = 0;
      #12;
      chk("init_stl0", int'(st0), 0);
      chk("init_hlt0", int'(h0),  0);
      chk("init_ret0", int'(rt0), 0);
      chk("init_svld1", int'(sv1), 0);
      rst_n = 1'b1;

      // Forwarding distance 1 and 2, register 0 never forwards.
      do_cycle(1, 1, 0, 0, 3, 0, 0, 0, 0, 0);
      do_cycle(1, 1, 0, 0, 4, 3, 0, 1, 0, 0);
      chk("fwd_d1_0", int'(fa0), 1);
      chk("fwd_d1_1", int'(fa1), 1);
      do_cycle(1, 0, 0, 0, 0, 3, 0, 1, 0, 0);
      chk("fwd_d2_0", int'(fa0), 2);
      do_cycle(1, 1, 0, 0, 0, 0, 0, 0, 0, 0);
      do_cycle(1, 0, 0, 0, 0, 0, 0, 1, 1, 0);
      chk("fwd_r0", int'(fa0), 0);
      bubbles(6);

      // Load-use: 1-cycle stall at LOAD_READY=1, 2 cycles at LOAD_READY=2.
      do_cycle(1, 1, 1, 0, 5, 0, 0, 0, 0, 0);
      do_cycle(1, 1, 0, 0, 6, 5, 0, 1, 0, 1);
      chk("ld_stl0_a", int'(st0), 1);
      chk("ld_stl1_a", int'(st1), 1);
      chk("ld_fl0_a",  int'(fl0), 0);
      do_cycle(1, 1, 0, 0, 6, 5, 0, 1, 0, 1);
      chk("ld_stl0_b", int'(st0), 0);
      chk("ld_fwd0_b", int'(fa0), 2);
      chk("ld_fl0_b",  int'(fl0), 1);
      chk("ld_stl1_b", int'(st1), 1);
      chk("ld_fl1_b",  int'(fl1), 0);
      do_cycle(1, 1, 0, 0, 6, 5, 0, 1, 0, 0);
      chk("ld_stl1_c", int'(st1), 0);
      chk("ld_fwd1_c", int'(fa1), 3);
      bubbles(6);

      // Halt drain: hlt at t+NSTG+1, retired sticky afterwards.
      do_cycle(1, 0, 0, 1, 0, 0, 0, 0, 0, 0);
      chk("hlt_acc0", int'(st0), 0);
      do_cycle(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      chk("hlt_stl0", int'(st0), 1);
      bubbles(2);
      chk("hlt_t3", int'(h0), 0);
      do_cycle(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      chk("hlt_t4", int'(h0), 1);
      bubbles(2);
      chk("hlt_t6", int'(h1), 1);
      bubbles(3);
      pulse_reset();

      // Reset while draining.
      do_cycle(1, 0, 0, 1, 0, 0, 0, 0, 0, 0);
      bubbles(2);
      chk("drain_stl", int'(st0), 1);
      pulse_reset();

      // 20 back-to-back instructions: 4-bit counter saturates.
      for (int j = 0; j < 20; j++) do_cycle(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      bubbles(6);
      chk("sat_ret1", int'(rt1), 15);
      chk("sat_ret0", int'(rt0), 20);

      // Producer aging through all five entries of the deep instance.
      do_cycle(1, 1, 0, 0, 7, 0, 0, 0, 0, 0);
      for (int j = 1; j <= 5; j++) begin
         do_cycle(1, 0, 0, 0, 0, 7, 0, 1, 0, 0);
         chk("fwd_age1", int'(fa1), j);
         chk("fwd_age0", int'(fa0), (j <= 3) ? j : 0);
      end
      pulse_reset();

      // Random traffic over a small register set to provoke hazards.
      for (int n = 0; n < 3000; n++) begin
         if ($urandom_range(0, 59) == 0) pulse_reset();
         else
            do_cycle($urandom_range(0, 9) < 8, $urandom_range(0, 9) < 7,
                     $urandom_range(0, 9) < 3, $urandom_range(0, 49) == 0,
                     4'($urandom_range(0, 3)), 4'($urandom_range(0, 3)),
                     4'($urandom_range(0, 3)), $urandom_range(0, 3) != 0,
                     $urandom_range(0, 1) == 1, $urandom_range(0, 4) == 0);
      end

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
